mod3_serial_sched: RTL and testbench

- Arbitrated front end for the serial divisible-by-3 residue engine.
- Two requesters each present a parallel WIDTH-bit word; the block grants one at a time, round-robin.
- The granted word is serialized MSB-first through an internal mod-3 residue state machine.
- The result (residue, multiple-of-3 flag, owner) is returned with a valid/ready handshake.

---
 rtl/mod3_serial_sched.sv | 158 +++++++++++++++
 tb/tb_mod3_serial_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod3_serial_sched.sv
// mod3_serial_sched
//   Round-robin front end for a serial divisible-by-3 residue engine. The
//   granted requester's word is shifted MSB-first through a three-state
//   residue machine (r' = (2r + b) mod 3). The result is then held until
//   the consumer accepts it.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high; clears all state
//   req[1:0]      per-requester request, held until the matching ack
//   data0/data1   WIDTH-bit operands, stable while the request is high
//   ack[1:0]      one-hot, one-cycle pulse: operand of requester i captured
//   busy          controller is not idle
//   done          result valid
//   result_ready  consumer accepts the result
//   is_mul3       captured operand mod 3 == 0
//   residue[1:0]  captured operand mod 3
//   owner         requester index of the current result
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures the winner
// SHIFT | consuming one operand bit per cycle, MSB first
// DONE  | result presented, waiting for result_ready

module mod3_serial_sched #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       ack,
  output logic             busy,
  output logic             done,
  input  logic             result_ready,
  output logic             is_mul3,
  output logic [1:0]       residue,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [1:0]       r_rs, w_rs_nxt;
  logic             r_last, w_last_nxt;
  logic [1:0]       r_ack, w_ack_nxt;
  logic             r_done, w_done_nxt;
  logic             r_is_mul3, w_is_mul3_nxt;
  logic [1:0]       r_residue, w_residue_nxt;
  logic             r_owner, w_owner_nxt;

  logic             w_win;
  logic             w_bit;
  logic [1:0]       w_rs_step;

  // On a tie the requester that was not served last wins; otherwise the
  // single active requester wins (req == 2'b10 -> 1, req == 2'b01 -> 0).
  assign w_win = (req == 2'b11) ? ~r_last : req[1];
  assign w_bit = r_shift[WIDTH-1];

  always_comb begin
    w_rs_step = 2'd0;
    case ({r_rs, w_bit})
      3'b00_0: w_rs_step = 2'd0;
      3'b00_1: w_rs_step = 2'd1;
      3'b01_0: w_rs_step = 2'd2;
      3'b01_1: w_rs_step = 2'd0;
      3'b10_0: w_rs_step = 2'd1;
      3'b10_1: w_rs_step = 2'd2;
      default: w_rs_step = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_rs_nxt      = r_rs;
    w_last_nxt    = r_last;
    w_ack_nxt     = 2'b00;
    w_done_nxt    = r_done;
    w_is_mul3_nxt = r_is_mul3;
    w_residue_nxt = r_residue;
    w_owner_nxt   = r_owner;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nxt = SHIFT;
          w_shift_nxt = w_win ? data1 : data0;
          w_cnt_nxt   = '0;
          w_rs_nxt    = 2'd0;
          w_owner_nxt = w_win;
          w_last_nxt  = w_win;
          w_ack_nxt   = w_win ? 2'b10 : 2'b01;
        end
      end
      SHIFT: begin
        w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
        w_cnt_nxt   = r_cnt + CW'(1);
        w_rs_nxt    = w_rs_step;
        // This edge consumes the LSB, so the stepped residue is final.
        if (r_cnt == LAST_BIT) begin
          w_state_nxt   = DONE;
          w_residue_nxt = w_rs_step;
          w_is_mul3_nxt = (w_rs_step == 2'd0);
          w_done_nxt    = 1'b1;
        end
      end
      DONE: begin
        if (result_ready) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_rs      <= 2'd0;
      r_last    <= 1'b1;
      r_ack     <= 2'b00;
      r_done    <= 1'b0;
      r_is_mul3 <= 1'b0;
      r_residue <= 2'd0;
      r_owner   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rs      <= w_rs_nxt;
      r_last    <= w_last_nxt;
      r_ack     <= w_ack_nxt;
      r_done    <= w_done_nxt;
      r_is_mul3 <= w_is_mul3_nxt;
      r_residue <= w_residue_nxt;
      r_owner   <= w_owner_nxt;
    end
  end

  assign ack     = r_ack;
  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign is_mul3 = r_is_mul3;
  assign residue = r_residue;
  assign owner   = r_owner;

endmodule

// File: tb/tb_mod3_serial_sched.sv
// tb_mod3_serial_sched
//   Scoreboard bench for mod3_serial_sched. Each issued request pushes its
//   expected (owner, residue) into a queue; a monitor pops and compares on
//   every accepted result (done && result_ready).

module tb_mod3_serial_sched;
  localparam int WIDTH = 8;
  localparam int CW    = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [WIDTH-1:0] data0, data1;
  logic [1:0]       ack;
  logic             busy, done, result_ready, is_mul3, owner;
  logic [1:0]       residue;

  logic rr_dir;
  logic rr_rand = 1'b0;
  logic rand_rr;
  assign result_ready = rand_rr ? rr_rand : rr_dir;

  always #5 clk = ~clk;

  mod3_serial_sched #(.WIDTH(WIDTH), .CW(CW)) u_dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .ack(ack), .busy(busy), .done(done), .result_ready(result_ready),
    .is_mul3(is_mul3), .residue(residue), .owner(owner)
  );

  typedef struct packed {
    logic       own;
    logic [1:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_issue = 0;
  int   n_ack   = 0;
  logic exp_last = 1'b1;
  logic [1:0] prev_ack = 2'b00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    rr_rand = 1'($urandom_range(0, 1));
  end

  // Monitor: ack pulse sanity and result comparison against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack != 2'b00) begin
        n_ack++;
        chk("ack_single_cycle", {30'd0, prev_ack}, 32'd0);
        chk("ack_while_busy", {31'd0, busy}, 32'd1);
      end
      if (done && result_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got residue %0d owner %0d expected none", residue, owner);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("residue", {30'd0, residue}, {30'd0, e.res});
          chk("is_mul3", {31'd0, is_mul3}, {31'd0, (e.res == 2'd0)});
          chk("owner", {31'd0, owner}, {31'd0, e.own});
        end
      end
    end
    prev_ack = ack;
  end

  // Raise req[idx] with operand d, expect requester idx to be granted with
  // residue er, then drop the request in the ack cycle.
  task automatic issue(input int idx, input logic [WIDTH-1:0] d, input logic [1:0] er);
    exp_t e;
    logic got;
    e.own = idx[0];
    e.res = er;
    sb.push_back(e);
    exp_last = idx[0];
    n_issue++;
    if (idx == 0) data0 = d;
    else          data1 = d;
    req[idx] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (ack != 2'b00) got = 1'b1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("ack_onehot", {30'd0, ack}, (idx == 0) ? 32'd1 : 32'd2);
      req = req & ~ack;
    end
  endtask

  // Called at the negedge of the ack cycle: done must rise exactly WIDTH
  // edges after the accept edge (WIDTH+1 edges counting the accept edge).
  task automatic check_latency();
    for (int k = 1; k <= WIDTH; k++) begin
      @(negedge clk);
      if (k == 1) chk("ack_one_cycle", {30'd0, ack}, 32'd0);
      chk("done_latency", {31'd0, done}, {31'd0, (k == WIDTH)});
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100 && busy; c++) @(negedge clk);
    chk("reach_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] cur [2];
    logic [WIDTH-1:0] d;
    int idx;
    int w;

    reset = 1'b1; req = 2'b00; data0 = '0; data1 = '0;
    rr_dir = 1'b0; rand_rr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_is_mul3", {31'd0, is_mul3}, 32'd0);
    chk("rst_residue", {30'd0, residue}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    step();
    reset = 1'b0;

    // single requester 0, result accepted immediately
    rr_dir = 1'b1;
    issue(0, 8'h09, 2'd0);
    check_latency();

    // requester 1 operands including all-ones and zero
    issue(1, 8'h0B, 2'd2);
    check_latency();
    issue(1, 8'hFF, 2'd0);
    issue(1, 8'h00, 2'd0);

    // both requesting: 0, then 1, then back to 0
    data1 = 8'h05; req[1] = 1'b1;
    issue(0, 8'h04, 2'd1);
    data0 = 8'h04; req[0] = 1'b1;
    issue(1, 8'h05, 2'd2);
    req[1] = 1'b1;
    issue(0, 8'h04, 2'd1);
    req = 2'b00;

    // result held while result_ready is low; requests ignored meanwhile
    wait_idle();
    rr_dir = 1'b0;
    issue(0, 8'h07, 2'd1);
    check_latency();
    for (int k = 0; k < 20; k++) begin
      step();
      req[1] = ~req[1];
      data1 = 8'($urandom);
      @(negedge clk);
      chk("hold_done", {31'd0, done}, 32'd1);
      chk("hold_residue", {30'd0, residue}, 32'd1);
      chk("hold_owner", {31'd0, owner}, 32'd0);
      chk("hold_no_ack", {30'd0, ack}, 32'd0);
    end
    step();
    req = 2'b00;
    rr_dir = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("done_fall", {31'd0, done}, 32'd0);

    // reset in the middle of SHIFT discards the operand
    issue(1, 8'h06, 2'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_owner", {31'd0, owner}, 32'd0);
    chk("mid_rst_residue", {30'd0, residue}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_ack", {30'd0, ack}, 32'd0);
    chk("sb_pending", sb.size(), 32'd1);
    sb.delete();
    exp_last = 1'b1;
    step();
    reset = 1'b0;
    issue(1, 8'h06, 2'd0);
    check_latency();

    // random sweep with random result_ready
    rand_rr = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      idx = int'($urandom_range(0, 1));
      d = 8'($urandom);
      issue(idx, d, 2'(d % 8'd3));
    end

    // both requesting continuously: grants must alternate
    cur[0] = 8'($urandom);
    cur[1] = 8'($urandom);
    data0 = cur[0];
    data1 = cur[1];
    req = 2'b11;
    for (int n = 0; n < 20; n++) begin
      w = int'(!exp_last);
      issue(w, cur[w], 2'(cur[w] % 8'd3));
      step();
      cur[w] = 8'($urandom);
      if (w == 0) data0 = cur[0];
      else        data1 = cur[1];
      req[w] = 1'b1;
    end
    req = 2'b00;

    rand_rr = 1'b0;
    rr_dir = 1'b1;
    for (int c = 0; c < 100 && (sb.size() != 0 || busy); c++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
    chk("ack_count", n_ack, n_issue);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
